stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Stopwatch core clocked by the divide-by-2 output of the clock divider stage, which drives its clk pin.
- Internal prescaler turns clk into a 1 Hz count tick.
- Keeps a 4-digit BCD MM:SS count, controlled by start/stop and clear pulses.
- Feeds the downstream 7-segment scan driver with packed BCD digits plus status flags.

Parameters:
- TICK_DIV, 25_000_000, clk cycles per count tick (25 MHz -> 1 Hz); legal range >= 2; benches use 4.
- CNT_W, $clog2(TICK_DIV), prescaler width; derived, not overridden.

Ports:
- clk  in  1  clock, from divider stage clk_div2 output.
- reset  in  1  asynchronous, active-low reset.
- start_stop  in  1  single-cycle pulse, pre-debounced; toggles run/pause.
- clear  in  1  single-cycle pulse, pre-debounced; zeroes count when not running.
- digits  out  16  BCD {min_tens, min_ones, sec_tens, sec_ones}, 4 bits each.
- running  out  1  high while in RUN.
- ovf  out  1  sticky; set on wrap 59:59 -> 00:00.
- tick  out  1  one-cycle strobe when the count advances.

Behaviour:
- Reset (reset=0, async): state=IDLE, prescaler=0, digits=16'h0000, running=0, ovf=0, tick=0. Reset mid-count discards everything. Release is sampled on the next clk rising edge.
- FSM states: IDLE, RUN, PAUSE. All transitions on the clk rising edge.
  - IDLE: start_stop -> RUN. clear -> IDLE (no-op).
  - RUN: start_stop -> PAUSE. clear ignored.
  - PAUSE: start_stop -> RUN. clear -> IDLE.
  - start_stop and clear in the same cycle:
    - In RUN, start_stop wins (-> PAUSE) and clear is dropped.
    - In PAUSE, clear wins (-> IDLE).
    - In IDLE, start_stop wins (-> RUN).
- Entering IDLE via clear: digits=0, prescaler=0, ovf=0, on the same edge.
- Prescaler:
  - Increments only in RUN.
  - At value TICK_DIV-1 it returns to 0 and the count advances on that same edge.
  - First advance occurs TICK_DIV edges after entering RUN.
  - Held (not reset) in PAUSE, so a partial second is preserved across a pause.
- tick: registered, high for exactly the one cycle after each advance edge.
- Start_stop in RUN on the same cycle the prescaler is at TICK_DIV-1: the advance still happens, then state -> PAUSE.
- Count arithmetic: BCD ripple on each advance.
  - sec_ones 0..9, carry into sec_tens.
  - sec_tens 0..5, carry into min_ones.
  - min_ones 0..9, carry into min_tens.
  - min_tens 0..5.
- Wrap: 59:59 + 1 -> 00:00; ovf set to 1 on that edge and held until clear or reset; counting continues after wrap.
- Digits never hold non-BCD values; min_tens and sec_tens never exceed 5.
- running = (state==RUN), registered output.
- No combinational path from any input to any output.

Decomposition:
- Package stopwatch_pkg:
  - state encoding (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2);
  - digit limit constants DIG_MAX_9=4'd9, DIG_MAX_5=4'd5.
- Sub-module bcd_digit:
  - parameter MAX;
  - inputs clk, reset, inc, clr;
  - outputs q[3:0], carry.
  - carry = inc && q==MAX, combinational. q wraps to 0 on carry.
  - Instantiated four times as a ripple chain.
- FSM, prescaler and ovf live in stopwatch_ctrl.

Test Plan:
- Reset then start_stop pulse (TICK_DIV=4): 4 edges later digits=16'h0001, tick high one cycle, running=1; after 40 edges digits=16'h0010.
- Pause/resume mid-second: run 6 edges (digits=0001, prescaler=2), pause 10 edges, resume. Next advance after exactly 2 more edges, so no lost partial second.
- Clear: clear during RUN leaves digits unchanged. Pause, then clear: digits=0000, ovf=0, running=0, state IDLE.
- Wrap: run to 59:59 (digits=16'h5959), next tick gives digits=16'h0000 and ovf=1. ovf stays 1 through further ticks until a clear in PAUSE.
- Simultaneous events: start_stop+clear in RUN -> PAUSE with digits kept. Both in PAUSE -> IDLE, zeroed. start_stop on a tick cycle -> digits advance and running=0.
- Async reset asserted mid-RUN between edges: outputs zero immediately without a clk edge. After release, stays IDLE until start_stop.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch core.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  localparam logic [3:0] DIG_MAX_9 = 4'd9;
  localparam logic [3:0] DIG_MAX_5 = 4'd5;

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// One BCD digit of the ripple counter: counts 0..MAX and carries out on wrap.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter logic [3:0] MAX = DIG_MAX_9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] q,
  output logic       carry
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  assign carry = inc && (q_q == MAX);

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 4'd0;
    end else if (carry) begin
      q_d = 4'd0;
    end else if (inc) begin
      q_d = q_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch core: run/pause/idle FSM, 1 Hz prescaler, MM:SS BCD count and sticky wrap flag.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000,
  localparam int CNT_W = $clog2(TICK_DIV)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_stop,
  input  logic        clear,
  output logic [15:0] digits,
  output logic        running,
  output logic        ovf,
  output logic        tick
);

  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic             ovf_q, ovf_d;
  logic             tick_q, tick_d;
  logic             running_q, running_d;
  logic             advance;
  logic             clr_all;
  logic [3:0]       carry;

  // Outputs are all registered; tick is a strobe marking the cycle in which digits has just changed.
  assign advance = (state_q == RUN) && (presc_q == PRESC_LAST);

  always_comb begin
    state_d = state_q;
    clr_all = 1'b0;
    case (state_q)
      IDLE:  if (start_stop) state_d = RUN;
      RUN:   if (start_stop) state_d = PAUSE;
      PAUSE: begin
        if (clear) begin
          state_d = IDLE;
          clr_all = 1'b1;
        end else if (start_stop) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Prescaler holds through PAUSE so a partial second survives a pause.
  always_comb begin
    presc_d = presc_q;
    if (clr_all) begin
      presc_d = '0;
    end else if (state_q == RUN) begin
      presc_d = advance ? '0 : presc_q + CNT_W'(1);
    end
  end

  always_comb begin
    ovf_d     = clr_all ? 1'b0 : (ovf_q | carry[3]);
    tick_d    = advance;
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      ovf_q     <= 1'b0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      ovf_q     <= ovf_d;
      tick_q    <= tick_d;
      running_q <= running_d;
    end
  end

  bcd_digit #(.MAX(DIG_MAX_9)) u_sec_ones (
    .clk(clk), .reset(reset), .inc(advance),  .clr(clr_all),
    .q(digits[3:0]),   .carry(carry[0])
  );
  bcd_digit #(.MAX(DIG_MAX_5)) u_sec_tens (
    .clk(clk), .reset(reset), .inc(carry[0]), .clr(clr_all),
    .q(digits[7:4]),   .carry(carry[1])
  );
  bcd_digit #(.MAX(DIG_MAX_9)) u_min_ones (
    .clk(clk), .reset(reset), .inc(carry[1]), .clr(clr_all),
    .q(digits[11:8]),  .carry(carry[2])
  );
  bcd_digit #(.MAX(DIG_MAX_5)) u_min_tens (
    .clk(clk), .reset(reset), .inc(carry[2]), .clr(clr_all),
    .q(digits[15:12]), .carry(carry[3])
  );

  assign running = running_q;
  assign ovf     = ovf_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with TICK_DIV=4: directed control sequences, tick-driven scoreboard.
module tb_stopwatch_ctrl;

  logic        clk;
  logic        reset;
  logic        start_stop;
  logic        clear;
  logic [15:0] digits;
  logic        running;
  logic        ovf;
  logic        tick;

  int errors = 0;
  int checks = 0;

  // Each entry is {ovf, digits} expected at the next tick strobe.
  logic [16:0] exp_q[$];
  int          secs   = 0;
  logic        m_ovf  = 1'b0;

  stopwatch_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear),
    .digits(digits), .running(running), .ovf(ovf), .tick(tick)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic push_secs(input int n);
    for (int i = 0; i < n; i++) begin
      secs = (secs + 1) % 3600;
      if (secs == 0) m_ovf = 1'b1;
      exp_q.push_back({m_ovf, to_bcd(secs)});
    end
  endtask

  task automatic model_clear();
    secs  = 0;
    m_ovf = 1'b0;
  endtask

  // driver tasks: inputs change 1 ns after a rising edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic ss, input logic cl);
    start_stop = ss;
    clear      = cl;
    @(posedge clk);
    #1;
    start_stop = 1'b0;
    clear      = 1'b0;
  endtask

  // scoreboard monitor
  initial begin : monitor
    logic [16:0] e;
    forever begin
      @(negedge clk);
      if (tick === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tick: got digits=%h ovf=%b with no advance expected at %0t",
                   digits, ovf, $time);
        end else begin
          e = exp_q.pop_front();
          check("tick_ovf_digits", {15'd0, ovf, digits}, {15'd0, e});
        end
      end
    end
  end

  initial begin : driver
    reset      = 1'b0;
    start_stop = 1'b0;
    clear      = 1'b0;
    step(3);
    check("rst_digits", digits, 16'h0000);
    check("rst_running", running, 0);
    check("rst_ovf", ovf, 0);
    check("rst_tick", tick, 0);
    reset = 1'b1;
    step(3);
    check("idle_running", running, 0);
    check("idle_digits", digits, 16'h0000);

    // start and count ten seconds
    pulse(1'b1, 1'b0);
    check("start_running", running, 1);
    push_secs(10);
    step(40);
    check("ten_sec_digits", digits, 16'h0010);

    // pause with prescaler at 2, then resume: advance after exactly 2 edges
    step(1);
    pulse(1'b1, 1'b0);
    check("pause_running", running, 0);
    step(10);
    check("pause_hold_digits", digits, 16'h0010);
    pulse(1'b1, 1'b0);
    push_secs(1);
    check("resume_running", running, 1);
    step(1);
    check("resume_no_early", digits, 16'h0010);
    step(1);
    check("resume_partial", digits, 16'h0011);

    // clear ignored in RUN, honoured in PAUSE
    pulse(1'b0, 1'b1);
    check("clr_run_digits", digits, 16'h0011);
    check("clr_run_running", running, 1);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    model_clear();
    check("clr_pause_digits", digits, 16'h0000);
    check("clr_pause_ovf", ovf, 0);
    check("clr_pause_running", running, 0);
    step(5);
    check("clr_idle_running", running, 0);
    check("clr_idle_digits", digits, 16'h0000);

    // wrap 59:59 -> 00:00
    pulse(1'b1, 1'b0);
    push_secs(3599);
    step(3599 * 4);
    check("pre_wrap_digits", digits, 16'h5959);
    check("pre_wrap_ovf", ovf, 0);
    push_secs(1);
    step(4);
    check("wrap_digits", digits, 16'h0000);
    check("wrap_ovf", ovf, 1);
    push_secs(2);
    step(8);
    check("post_wrap_digits", digits, 16'h0002);
    check("post_wrap_ovf", ovf, 1);

    // start_stop on the advance edge: count still advances, then pause
    step(3);
    push_secs(1);
    pulse(1'b1, 1'b0);
    check("ss_tick_digits", digits, 16'h0003);
    check("ss_tick_running", running, 0);
    check("ss_tick_ovf", ovf, 1);

    // both pulses in PAUSE: clear wins
    pulse(1'b1, 1'b1);
    model_clear();
    check("both_pause_digits", digits, 16'h0000);
    check("both_pause_ovf", ovf, 0);
    check("both_pause_running", running, 0);

    // both pulses in IDLE: start wins
    pulse(1'b1, 1'b1);
    check("both_idle_running", running, 1);
    push_secs(2);
    step(8);
    step(1);

    // both pulses in RUN: pause, digits kept
    pulse(1'b1, 1'b1);
    check("both_run_running", running, 0);
    check("both_run_digits", digits, 16'h0002);
    step(3);
    check("both_run_hold", digits, 16'h0002);

    // async reset between edges while running
    pulse(1'b1, 1'b0);
    push_secs(1);
    step(3);
    check("pre_rst_digits", digits, 16'h0003);
    #2;
    reset = 1'b0;
    #1;
    model_clear();
    check("async_rst_digits", digits, 16'h0000);
    check("async_rst_running", running, 0);
    check("async_rst_tick", tick, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(6);
    check("post_rst_running", running, 0);
    check("post_rst_digits", digits, 16'h0000);

    step(2);
    check("exp_queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
